// File: rtl/mac_neuron_if.sv
// Term/result bundle between an upstream term source and the mac_neuron stage.
// The master drives terms and bias; the slave (the neuron) drives results.
interface mac_neuron_if #(
  parameter int DATA_W = 16
);
  logic              din_valid;
  logic [DATA_W-1:0] din_x;
  logic [DATA_W-1:0] din_w;
  logic [31:0]       bias;
  logic [31:0]       dout_mac;
  logic              dout_valid;
  logic              dout_sat;

  modport master (
    output din_valid, din_x, din_w, bias,
    input  dout_mac, dout_valid, dout_sat
  );

  modport slave (
    input  din_valid, din_x, din_w, bias,
    output dout_mac, dout_valid, dout_sat
  );
endinterface

// File: rtl/mac_neuron.sv
// Streaming multiply-accumulate neuron: N signed terms plus a bias per vector,
// result saturated to 32-bit signed and presented two edges after the last term.
module mac_neuron #(
  parameter int DATA_W = 16,
  parameter int N      = 4,
  parameter int ACC_W  = 40
) (
  input  logic         clk,
  input  logic         rst,
  mac_neuron_if.slave  bus
);
  localparam int              CNT_W  = $clog2(N);
  localparam int              PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] p_reg_q, p_reg_d;
  logic signed [ACC_W-1:0] b_reg_q, b_reg_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    p_valid_q, p_valid_d;
  logic                    p_first_q, p_first_d;
  logic                    p_last_q, p_last_d;
  logic [31:0]             s_mac_q, s_mac_d;
  logic                    s_sat_q, s_sat_d;
  logic                    s_valid_q, s_valid_d;
  logic [31:0]             dout_mac_q, dout_mac_d;
  logic                    dout_sat_q, dout_sat_d;
  logic                    dout_valid_q, dout_valid_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic [ACC_W-32:0]        sum_top;
  logic                     sat_hi, sat_lo;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d        = cnt_q;
    p_reg_d      = p_reg_q;
    b_reg_d      = b_reg_q;
    p_first_d    = p_first_q;
    p_last_d     = p_last_q;
    p_valid_d    = 1'b0;
    acc_d        = acc_q;
    s_mac_d      = s_mac_q;
    s_sat_d      = s_sat_q;
    s_valid_d    = 1'b0;

    // Size casts of signed operands sign-extend before the multiply.
    prod = PROD_W'($signed(bus.din_x)) * PROD_W'($signed(bus.din_w));

    if (bus.din_valid) begin
      cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      p_reg_d   = ACC_W'(prod);
      p_first_d = (cnt_q == '0);
      p_last_d  = (cnt_q == LAST);
      p_valid_d = 1'b1;
      if (cnt_q == '0) begin
        b_reg_d = ACC_W'($signed(bus.bias));
      end
    end

    // Selecting the bias on the first term lets a new vector follow the
    // previous one's last term with no bubble.
    sum     = (p_first_q ? b_reg_q : acc_q) + p_reg_q;
    sum_top = sum[ACC_W-1:31];
    sat_hi  = !sum[ACC_W-1] && (|sum_top);
    sat_lo  = sum[ACC_W-1] && !(&sum_top);

    if (p_valid_q) begin
      acc_d = sum;
      if (p_last_q) begin
        s_valid_d = 1'b1;
        s_sat_d   = sat_hi | sat_lo;
        if (sat_hi)      s_mac_d = 32'h7FFF_FFFF;
        else if (sat_lo) s_mac_d = 32'h8000_0000;
        else             s_mac_d = sum[31:0];
      end
    end

    dout_valid_d = s_valid_q;
    dout_mac_d   = s_valid_q ? s_mac_q : dout_mac_q;
    dout_sat_d   = s_valid_q ? s_sat_q : dout_sat_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      p_reg_q      <= '0;
      b_reg_q      <= '0;
      acc_q        <= '0;
      p_valid_q    <= 1'b0;
      p_first_q    <= 1'b0;
      p_last_q     <= 1'b0;
      s_mac_q      <= '0;
      s_sat_q      <= 1'b0;
      s_valid_q    <= 1'b0;
      dout_mac_q   <= '0;
      dout_sat_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      p_reg_q      <= p_reg_d;
      b_reg_q      <= b_reg_d;
      acc_q        <= acc_d;
      p_valid_q    <= p_valid_d;
      p_first_q    <= p_first_d;
      p_last_q     <= p_last_d;
      s_mac_q      <= s_mac_d;
      s_sat_q      <= s_sat_d;
      s_valid_q    <= s_valid_d;
      dout_mac_q   <= dout_mac_d;
      dout_sat_q   <= dout_sat_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.dout_mac   = dout_mac_q;
  assign bus.dout_sat   = dout_sat_q;
  assign bus.dout_valid = dout_valid_q;
endmodule
